// File: rtl/sram_rd_burst_arbiter.sv
// sram_rd_burst_arbiter
// Shares the read port of one SRAM channel among NUM_REQ requesters.
// A burst (start address, word count) is granted round-robin and then issued
// as consecutive rd_en/rd_addr cycles. The 1-cycle-latency SRAM data comes
// back on a valid/ready response stream that is tagged with the owner id.
// Optional feature macro: SRAM_ARB_SIZE_WRAP_EN
//   defined   -> address counter wraps from SIZE-1 to 0 (non-power-of-2 SIZE)
//   undefined -> address counter wraps only at 2^ADDR_WIDTH
module sram_rd_burst_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int SIZE       = 256,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          sram_rd_en,
   output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]         sram_rd_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic                          rsp_last,
   output logic                          done,
   output logic                          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   owner;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [LEN_WIDTH-1:0]  remaining;

   logic                  grant_any;
   logic [NUM_REQ-1:0]    grant_vec;
   logic [ID_WIDTH-1:0]   grant_id;
   logic [ID_WIDTH-1:0]   next_rr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LEN_WIDTH-1:0]  sel_len;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  issue;

   // Parameter sanity: ids must cover all requesters and SIZE must fit the address space
   if ((NUM_REQ < 2) || ((2 ** ID_WIDTH) < NUM_REQ) || (SIZE > (2 ** ADDR_WIDTH)) || (SIZE < 1)) begin : g_param_check
      $error("sram_rd_burst_arbiter: inconsistent NUM_REQ/ID_WIDTH/SIZE/ADDR_WIDTH");
   end

   // Round-robin search: first pass looks at requesters >= rr_ptr, second pass wraps to the rest
   always_comb begin
      grant_any = 1'b0;
      grant_vec = '0;
      grant_id  = '0;
      sel_addr  = '0;
      sel_len   = '0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && req_valid[j] && ((pass == 1) || (j >= int'(rr_ptr)))) begin
               grant_any    = 1'b1;
               grant_vec[j] = 1'b1;
               grant_id     = ID_WIDTH'(j);
               sel_addr     = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
               sel_len      = req_len[j*LEN_WIDTH +: LEN_WIDTH];
            end
         end
      end
   end

   // Pointer after a grant moves just past the winner, modulo NUM_REQ
   always_comb begin
      next_rr = grant_id + ID_WIDTH'(1);
      if (grant_id == ID_WIDTH'(NUM_REQ - 1)) begin
         next_rr = '0;
      end
   end

   // Next read address, wrapping at SIZE or at the natural address width
   always_comb begin
`ifdef SRAM_ARB_SIZE_WRAP_EN
      next_addr = addr_cnt + ADDR_WIDTH'(1);
      if (addr_cnt == ADDR_WIDTH'(SIZE - 1)) begin
         next_addr = '0;
      end
`else
      next_addr = addr_cnt + ADDR_WIDTH'(1);
`endif
   end

   // A new word may be read only when the response slot is empty or draining this cycle
   always_comb begin
      issue = (state == BURST) && (remaining != '0) && (!rsp_valid || rsp_ready);
   end

   // Accept pulse exists only while idle; held off while reset is asserted
   always_comb begin
      req_ready = '0;
      if ((state == IDLE) && !rst) begin
         req_ready = grant_vec;
      end
   end

   assign sram_rd_en   = issue;
   assign sram_rd_addr = addr_cnt;
   assign rsp_data     = sram_rd_data;
   assign rsp_id       = owner;
   assign done         = (state == DONE);
   assign busy         = (state != IDLE);

   // Main controller: grant, burst issue with response backpressure, then a done cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         addr_cnt  <= '0;
         remaining <= '0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner     <= grant_id;
                  addr_cnt  <= sel_addr;
                  remaining <= sel_len;
                  rr_ptr    <= next_rr;
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  state     <= (sel_len != '0) ? BURST : DONE;
               end
            end
            BURST: begin
               if (issue) begin
                  addr_cnt  <= next_addr;
                  remaining <= remaining - LEN_WIDTH'(1);
                  rsp_valid <= 1'b1;
                  rsp_last  <= (remaining == LEN_WIDTH'(1));
               end else if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_last) begin
                     rsp_last <= 1'b0;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
